keccak_round_ctrl: RTL
======================

Name: keccak_round_ctrl

Overview:
- Sequencer for the Keccak-f[1600] step datapath.
- Accepts a mode configuration and drives the configuration outputs (rate, capacity, suffix) that the absorb/pad logic reads.
- On request, walks the step datapath through THETA, RHO, PI, CHI, IOTA for 24 rounds, one step per cycle, presenting step_sel and round_idx.
- Also issues single-cycle ZERO_STEP state clears. Sits between the sponge-level FSM and the state-array step unit.

Parameters:
- NUM_ROUNDS, 24 (MAX_ROUNDS): rounds per permutation; legal range 1..24.
- RI_W, 5 (ROUND_INDEX_SIZE): width of round_idx.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mode_valid  in  1  configuration handshake valid
- mode  in  2  keccak_mode encoding (SHA3_256=0, SHA3_512=1, SHAKE128=2, SHAKE256=3)
- mode_ready  out  1  high only in IDLE
- zero_req  in  1  level request to clear the state array
- perm_req  in  1  level request to run one permutation
- perm_ack  out  1  one-cycle pulse when perm_req is accepted
- abort  in  1  terminate a running permutation
- step_sel  out  3  keccak_step value driven to the datapath
- round_idx  out  RI_W  current round index (for iota RC lookup)
- busy  out  1  high in ZERO or RUN
- perm_done  out  1  one-cycle pulse after the final IOTA
- rate  out  11  rate in bits for the latched mode
- capacity  out  11  capacity in bits
- suffix  out  8  domain-separation suffix byte
- suffix_len  out  3  valid suffix bits

Behaviour:
- Reset values (async, immediate):
  - FSM IDLE; step_sel=IDLE_STEP, round_idx=0.
  - perm_ack, perm_done, busy = 0; mode_ready = 1.
  - Latched mode SHA3_256: rate=1088, capacity=512, suffix=0x06, suffix_len=2.
- FSM states: IDLE, ZERO, RUN, DONE.
- Configuration:
  - mode_valid && mode_ready latches mode in that cycle; outputs update the next cycle.
  - Decode: SHA3_256 → 1088/512/0x06/2; SHA3_512 → 576/1024/0x06/2; SHAKE128 → 1344/256/0x1F/4; SHAKE256 → 1088/512/0x1F/4.
  - All decode outputs are registered.
  - mode_valid outside IDLE is ignored (mode_ready=0) and not latched.
- IDLE transitions:
  - zero_req → ZERO. Zero has priority when zero_req and perm_req are both high; perm_req stays pending and is not acked.
  - Else perm_req → RUN, with perm_ack pulsed in the same cycle, round_idx=0, first step THETA.
  - If mode_valid and a request arrive together, the mode is latched and the request is accepted in the same cycle. The request uses the new mode only for config outputs, which is irrelevant to stepping.
- ZERO:
  - step_sel=ZERO_STEP for exactly one cycle, then IDLE.
  - abort has no effect in ZERO.
- RUN:
  - step_sel advances THETA→RHO→PI→CHI→IOTA, one cycle each.
  - After IOTA: if round_idx==NUM_ROUNDS-1 → DONE, else round_idx+1 and THETA.
  - round_idx is constant across all steps of a round.
  - perm_req and zero_req are ignored while in RUN.
- DONE:
  - One cycle: perm_done=1, step_sel=IDLE_STEP, round_idx=0, then IDLE.
  - A perm_req held high in DONE is not accepted until IDLE (earliest next cycle).
- Latency: with acceptance at cycle 0, THETA of round 0 is at cycle 1 and the last IOTA at cycle 120. perm_done is at cycle 121; next acceptance is possible at cycle 122.
- Abort:
  - High in RUN → next cycle IDLE, step_sel=IDLE_STEP, round_idx=0, no perm_done.
  - Ignored in IDLE, ZERO, DONE.
- Outside ZERO and RUN, step_sel is always IDLE_STEP.
- Reset mid-RUN: all outputs take reset values immediately. No done pulse is generated.

Optional Feature:
- Macro KECCAK_FUSED_RHO_PI_EN.
  - Defined: RUN sequence per round is THETA→RHO→CHI→IOTA. RHO_STEP means the datapath performs rho and pi in one cycle. PI_STEP is never issued. Permutation takes 4*NUM_ROUNDS cycles; perm_done is at cycle 97 for 24 rounds.
  - Undefined: the five-step sequence as above.

Test Plan:
- Reset, then check idle outputs → step_sel=IDLE_STEP, mode_ready=1, rate=1088, capacity=512, suffix=0x06, suffix_len=2.
- mode=2 with mode_valid for 1 cycle → next cycle rate=1344, capacity=256, suffix=0x1F, suffix_len=4. Then mode=1 while RUN → ignored.
- perm_req pulse at cycle 0:
  - perm_ack at cycle 0.
  - Cycle 1: step_sel=THETA, round_idx=0. Cycle 6: THETA, round_idx=1.
  - Cycle 120: IOTA, round_idx=23. Cycle 121: perm_done=1. busy=0 at cycle 122.
  - Fused build: perm_done at cycle 97 and no PI_STEP ever observed.
- zero_req and perm_req high together in IDLE → one ZERO_STEP cycle with perm_ack=0, then perm_ack and RUN start the cycle after.
- abort during round 7 CHI → next cycle step_sel=IDLE_STEP, round_idx=0, busy=0, and perm_done never pulses. A fresh perm_req then restarts at round 0 THETA.
- Assert rst during round 12 PI → outputs reset immediately. After release, perm_req gives a full 24-round sequence and perm_done at cycle 121.

Source files
------------

// File: rtl/keccak_round_ctrl.sv
// keccak_round_ctrl: sequencer for the Keccak-f[1600] step datapath.
// Latches the sponge mode and drives registered rate/capacity/suffix
// outputs, issues single-cycle ZERO_STEP clears, and walks the step unit
// through THETA, RHO, PI, CHI, IOTA for NUM_ROUNDS rounds.
// Build option: define KECCAK_FUSED_RHO_PI_EN to drop PI_STEP. RHO_STEP
// then tells the datapath to do rho and pi in the same cycle, so each
// round takes four cycles instead of five.
module keccak_round_ctrl #(
    parameter int NUM_ROUNDS = 24,
    parameter int RI_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode_valid,
    input  logic [1:0]      mode,
    output logic            mode_ready,
    input  logic            zero_req,
    input  logic            perm_req,
    output logic            perm_ack,
    input  logic            abort,
    output logic [2:0]      step_sel,
    output logic [RI_W-1:0] round_idx,
    output logic            busy,
    output logic            perm_done,
    output logic [10:0]     rate,
    output logic [10:0]     capacity,
    output logic [7:0]      suffix,
    output logic [2:0]      suffix_len
);

    // Step codes seen by the datapath.
    localparam logic [2:0] IDLE_STEP  = 3'd0;
    localparam logic [2:0] THETA_STEP = 3'd1;
    localparam logic [2:0] RHO_STEP   = 3'd2;
    localparam logic [2:0] PI_STEP    = 3'd3;
    localparam logic [2:0] CHI_STEP   = 3'd4;
    localparam logic [2:0] IOTA_STEP  = 3'd5;
    localparam logic [2:0] ZERO_STEP  = 3'd6;

    // Controller states.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ZERO = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // keccak_mode encoding.
    localparam logic [1:0] SHA3_256 = 2'd0;
    localparam logic [1:0] SHA3_512 = 2'd1;
    localparam logic [1:0] SHAKE128 = 2'd2;
    localparam logic [1:0] SHAKE256 = 2'd3;

    localparam logic [RI_W-1:0] LAST_ROUND = RI_W'(NUM_ROUNDS - 1);

    logic [1:0]      state;
    logic [2:0]      step;
    logic [RI_W-1:0] round;
    logic            in_idle;

    // Successor of a non-final step inside one round.
    function automatic logic [2:0] next_step(input logic [2:0] cur);
        logic [2:0] nxt;
        nxt = THETA_STEP;
        case (cur)
            THETA_STEP: nxt = RHO_STEP;
`ifdef KECCAK_FUSED_RHO_PI_EN
            RHO_STEP:   nxt = CHI_STEP;
`else
            RHO_STEP:   nxt = PI_STEP;
`endif
            PI_STEP:    nxt = CHI_STEP;
            CHI_STEP:   nxt = IOTA_STEP;
            default:    nxt = THETA_STEP;
        endcase
        return nxt;
    endfunction

    assign in_idle = (state == S_IDLE);

    // Handshake and status outputs decode straight from the state so that
    // an asynchronous reset forces them to their idle values immediately.
    assign mode_ready = in_idle;
    assign perm_ack   = in_idle && perm_req && !zero_req;
    assign busy       = (state == S_ZERO) || (state == S_RUN);
    assign perm_done  = (state == S_DONE);
    assign round_idx  = (state == S_RUN) ? round : '0;

    // Step select: the live step only in RUN, a clear in ZERO, idle otherwise.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        step_sel = IDLE_STEP;
        if (state == S_RUN)       step_sel = step;
        else if (state == S_ZERO) step_sel = ZERO_STEP;
    end

    // Controller FSM with round and step tracking.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (rst) begin
            state <= S_IDLE;
            step  <= THETA_STEP;
            round <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (zero_req) begin
                        // A clear wins; a concurrent perm_req stays pending.
                        state <= S_ZERO;
                    end else if (perm_req) begin
                        state <= S_RUN;
                        step  <= THETA_STEP;
                        round <= '0;
                    end
                end
                S_ZERO: state <= S_IDLE;
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (step == IOTA_STEP) begin
                        if (round == LAST_ROUND) begin
                            state <= S_DONE;
                        end else begin
                            round <= round + RI_W'(1);
                            step  <= THETA_STEP;
                        end
                    end else begin
                        step <= next_step(step);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Mode latch and registered configuration decode; only accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate       <= 11'd1088;
            capacity   <= 11'd512;
            suffix     <= 8'h06;
            suffix_len <= 3'd2;
        end else if (mode_valid && in_idle) begin
            case (mode)
                SHA3_256: begin
                    rate <= 11'd1088; capacity <= 11'd512;
                    suffix <= 8'h06;  suffix_len <= 3'd2;
                end
                SHA3_512: begin
                    rate <= 11'd576;  capacity <= 11'd1024;
                    suffix <= 8'h06;  suffix_len <= 3'd2;
                end
                SHAKE128: begin
                    rate <= 11'd1344; capacity <= 11'd256;
                    suffix <= 8'h1F;  suffix_len <= 3'd4;
                end
                SHAKE256: begin
                    rate <= 11'd1088; capacity <= 11'd512;
                    suffix <= 8'h1F;  suffix_len <= 3'd4;
                end
                default: begin
                    rate <= 11'd1088; capacity <= 11'd512;
                    suffix <= 8'h06;  suffix_len <= 3'd2;
                end
            endcase
        end
    end

endmodule
